kc_ls1u_mem_arbiter: RTL and testbench

//  Two-master arbiter/sequencer for one shared single-port synchronous data RAM. Master 0 is the
//  KC_LS1u data port (daddr/ddata/dwrite). Master 1 is a DMA/debug loader. Serialises accesses,

---
 rtl/kc_ls1u_mem_arbiter_if.sv | 14 +
 rtl/kc_ls1u_mem_arbiter.sv | 108 ++++++++++
 tb/tb_kc_ls1u_mem_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/kc_ls1u_mem_arbiter_if.sv
// kc_ls1u_mem_arbiter_if: one master's request/response channel into the shared-RAM arbiter
interface kc_ls1u_mem_arbiter_if #(
    parameter int AW = 24,
    parameter int DW = 8
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ack;
    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/kc_ls1u_mem_arbiter.sv
// kc_ls1u_mem_arbiter: serialises two masters onto one single-port synchronous RAM with read latency and ack
module kc_ls1u_mem_arbiter #(
    parameter int AW       = 24,
    parameter int DW       = 8,
    parameter int RD_LAT   = 2,
    parameter int ARB_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    kc_ls1u_mem_arbiter_if.slave m0,
    kc_ls1u_mem_arbiter_if.slave m1,
    output logic                 m0_wait,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, LAT, ACK} state_t;
    state_t        state_q, state_d;
    logic          gnt_q, gnt_d, last_q, last_d, pick1;
    logic [3:0]    cnt_q, cnt_d;
    logic          cs_q, cs_d, we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d, rd0_q, rd0_d, rd1_q, rd1_d;
    logic          ack0_q, ack0_d, ack1_q, ack1_d;
    always_comb begin
        // m1 wins only when alone, or in round-robin when m0 held the last grant
        pick1   = m1.req & (~m0.req | (ARB_MODE == 0 && !last_q));
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        cs_d    = 1'b0;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        case (state_q)
            IDLE: if (m0.req | m1.req) begin
                state_d = ISSUE;
                gnt_d   = pick1;
                last_d  = pick1;
                cs_d    = 1'b1;
                we_d    = pick1 ? m1.we : m0.we;
                addr_d  = pick1 ? m1.addr : m0.addr;
                wdata_d = pick1 ? m1.wdata : m0.wdata;
            end
            ISSUE: begin
                state_d = we_q ? ACK : LAT;
                cnt_d   = 4'(RD_LAT - 1);
                ack0_d  = we_q & ~gnt_q;
                ack1_d  = we_q & gnt_q;
            end
            LAT: if (cnt_q == 4'd0) begin
                state_d = ACK;
                ack0_d  = ~gnt_q;
                ack1_d  = gnt_q;
                rd0_d   = gnt_q ? rd0_q : mem_rdata;
                rd1_d   = gnt_q ? mem_rdata : rd1_q;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end
    assign mem_cs    = cs_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign m0.ack    = ack0_q;
    assign m1.ack    = ack1_q;
    assign m0.rdata  = rd0_q;
    assign m1.rdata  = rd1_q;
    assign m0_wait   = m0.req & ~ack0_q;
endmodule

// File: tb/tb_kc_ls1u_mem_arbiter.sv
// tb_kc_ls1u_mem_arbiter: scoreboard bench; dut A is RD_LAT=2 round-robin, dut B is RD_LAT=1 fixed priority
module tb_kc_ls1u_mem_arbiter;
    typedef struct {int ch; int cyc; bit rd; logic [7:0] rdata;} ack_t;
    typedef struct {int d; int cyc; bit we; logic [23:0] addr; logic [7:0] wdata;} mem_t;
    ack_t qa[$];
    mem_t qm[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic wait_a, cs_a, we_a, wait_b, cs_b, we_b;
    logic [23:0] addr_a, addr_b;
    logic [7:0] wd_a, wd_b, rd_a, rd_b;
    logic [7:0] ram_a [256];
    logic [7:0] ram_b [256];
    logic [1:0] va = '0;
    logic vb = 1'b0;
    logic [7:0] pa0, pa1, pb;

    kc_ls1u_mem_arbiter_if #(.AW(24), .DW(8)) a0 ();
    kc_ls1u_mem_arbiter_if #(.AW(24), .DW(8)) a1 ();
    kc_ls1u_mem_arbiter_if #(.AW(24), .DW(8)) b0 ();
    kc_ls1u_mem_arbiter_if #(.AW(24), .DW(8)) b1 ();

    kc_ls1u_mem_arbiter #(.AW(24), .DW(8), .RD_LAT(2), .ARB_MODE(0)) u_a (
        .clk(clk), .rst(rst), .m0(a0), .m1(a1), .m0_wait(wait_a), .mem_cs(cs_a), .mem_we(we_a),
        .mem_addr(addr_a), .mem_wdata(wd_a), .mem_rdata(rd_a));
    kc_ls1u_mem_arbiter #(.AW(24), .DW(8), .RD_LAT(1), .ARB_MODE(1)) u_b (
        .clk(clk), .rst(rst), .m0(b0), .m1(b1), .m0_wait(wait_b), .mem_cs(cs_b), .mem_we(we_b),
        .mem_addr(addr_b), .mem_wdata(wd_b), .mem_rdata(rd_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM models drive 8'hEE outside the valid read cycle so mistimed captures show up
    always @(posedge clk) begin
        va  <= {va[0], cs_a & ~we_a};
        pa0 <= ram_a[addr_a[7:0]];
        pa1 <= pa0;
        if (cs_a && we_a) ram_a[addr_a[7:0]] = wd_a;
    end
    assign rd_a = va[1] ? pa1 : 8'hEE;
    always @(posedge clk) begin
        vb <= cs_b & ~we_b;
        pb <= ram_b[addr_b[7:0]];
        if (cs_b && we_b) ram_b[addr_b[7:0]] = wd_b;
    end
    assign rd_b = vb ? pb : 8'hEE;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic exp_ack(input int ch, input int c, input bit rd, input logic [7:0] v);
        ack_t e;
        e.ch = ch; e.cyc = c; e.rd = rd; e.rdata = v;
        qa.push_back(e);
    endtask

    task automatic exp_mem(input int d, input int c, input bit we, input logic [23:0] ad, input logic [7:0] wd);
        mem_t e;
        e.d = d; e.cyc = c; e.we = we; e.addr = ad; e.wdata = wd;
        qm.push_back(e);
    endtask

    task automatic chk_ack(input int ch, input logic ack, input logic [7:0] rd);
        ack_t e;
        if (ack) begin
            tests++;
            if (qa.size() == 0) begin
                fails++;
                $display("FAIL ack_unexpected: ch%0d acked at cyc %0d, required no ack", ch, cyc);
            end else begin
                e = qa.pop_front();
                if (e.ch != ch || e.cyc != cyc || (e.rd && e.rdata !== rd)) begin
                    fails++;
                    $display("FAIL ack: got ch%0d cyc %0d rdata %h, required ch%0d cyc %0d rdata %h",
                             ch, cyc, rd, e.ch, e.cyc, e.rdata);
                end
            end
        end
    endtask

    task automatic chk_mem(input int d, input logic cs, input logic we, input logic [23:0] ad, input logic [7:0] wd);
        mem_t e;
        if (cs) begin
            tests++;
            if (qm.size() == 0) begin
                fails++;
                $display("FAIL mem_cs_unexpected: dut%0d cs at cyc %0d, required none", d, cyc);
            end else begin
                e = qm.pop_front();
                if (e.d != d || e.cyc != cyc || e.we != we || e.addr !== ad || e.wdata !== wd) begin
                    fails++;
                    $display("FAIL mem: got dut%0d cyc %0d we %b addr %h wdata %h, required dut%0d cyc %0d we %b addr %h wdata %h",
                             d, cyc, we, ad, wd, e.d, e.cyc, e.we, e.addr, e.wdata);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk_ack(0, a0.ack, a0.rdata);
            chk_ack(1, a1.ack, a1.rdata);
            chk_ack(2, b0.ack, b0.rdata);
            chk_ack(3, b1.ack, b1.rdata);
            chk_mem(0, cs_a, we_a, addr_a, wd_a);
            chk_mem(1, cs_b, we_b, addr_b, wd_b);
        end
    end

    task automatic drv(input int ch, input bit r, input bit w, input logic [23:0] ad, input logic [7:0] wd);
        case (ch)
            0: begin a0.req = r; a0.we = w; a0.addr = ad; a0.wdata = wd; end
            1: begin a1.req = r; a1.we = w; a1.addr = ad; a1.wdata = wd; end
            2: begin b0.req = r; b0.we = w; b0.addr = ad; b0.wdata = wd; end
            default: begin b1.req = r; b1.we = w; b1.addr = ad; b1.wdata = wd; end
        endcase
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // lone access: request in cycle t, drop it in the IDLE cycle after the ack
    task automatic single(input int d, input int ch, input bit we, input logic [23:0] ad, input logic [7:0] wd,
                          input bit rd, input logic [7:0] rv, input int lat);
        int s, off;
        s = cyc;
        off = we ? 2 : 2 + lat;
        exp_mem(d, s + 1, we, ad, wd);
        exp_ack(ch, s + off, rd, rv);
        drv(ch, 1, we, ad, wd);
        step(off + 1);
        drv(ch, 0, 0, 24'h0, 8'h0);
        step(1);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        step(2);
    endtask

    initial begin
        ram_a[8'h40] = 8'h3C;
        ram_b[8'h40] = 8'h77;
        for (int i = 0; i < 4; i++) drv(i, 0, 0, 24'h0, 8'h0);
        step(2);
        @(negedge clk);
        chk("reset_a", {cs_a, we_a, addr_a, wd_a, a0.ack, a1.ack, a0.rdata, a1.rdata, wait_a}, 64'h0);
        chk("reset_b", {cs_b, we_b, addr_b, wd_b, b0.ack, b1.ack, b0.rdata, b1.rdata, wait_b}, 64'h0);
        step(1);
        rst = 1'b1;
        step(2);
        // m0 write with stall profile
        t = cyc;
        exp_mem(0, t + 1, 1, 24'h000123, 8'hA5);
        exp_ack(0, t + 2, 0, 8'h00);
        drv(0, 1, 1, 24'h000123, 8'hA5);
        @(negedge clk) chk("wait_t", wait_a, 1);
        @(negedge clk) chk("wait_t1", wait_a, 1);
        @(negedge clk) chk("wait_t2", wait_a, 0);
        step(1);
        drv(0, 0, 0, 24'h0, 8'h0);
        step(2);
        // reads with latency 2 and 1, then a write that must leave rdata alone
        single(0, 0, 0, 24'h000040, 8'h5A, 1, 8'h3C, 2);
        single(0, 0, 1, 24'h000041, 8'h99, 1, 8'h3C, 2);
        single(1, 2, 0, 24'h000040, 8'h00, 1, 8'h77, 1);
        // round-robin with both masters streaming writes from reset
        pulse_reset();
        t = cyc;
        exp_mem(0, t + 1, 1, 24'h000100, 8'h10);  exp_ack(0, t + 2, 0, 8'h00);
        exp_mem(0, t + 4, 1, 24'h000200, 8'h20);  exp_ack(1, t + 5, 0, 8'h00);
        exp_mem(0, t + 7, 1, 24'h000101, 8'h11);  exp_ack(0, t + 8, 0, 8'h00);
        exp_mem(0, t + 10, 1, 24'h000201, 8'h21); exp_ack(1, t + 11, 0, 8'h00);
        drv(0, 1, 1, 24'h000100, 8'h10);
        drv(1, 1, 1, 24'h000200, 8'h20);
        step(3); drv(0, 1, 1, 24'h000101, 8'h11);
        step(3); drv(1, 1, 1, 24'h000201, 8'h21);
        step(3); drv(0, 1, 1, 24'h000102, 8'h12);
        step(3); drv(0, 0, 0, 24'h0, 8'h0); drv(1, 0, 0, 24'h0, 8'h0);
        step(2);
        // fixed priority: m1 starves until m0 lets go
        t = cyc;
        exp_mem(1, t + 1, 1, 24'h000300, 8'h30); exp_ack(2, t + 2, 0, 8'h00);
        exp_mem(1, t + 4, 1, 24'h000301, 8'h31); exp_ack(2, t + 5, 0, 8'h00);
        exp_mem(1, t + 7, 1, 24'h000400, 8'h40); exp_ack(3, t + 8, 0, 8'h00);
        drv(2, 1, 1, 24'h000300, 8'h30);
        drv(3, 1, 1, 24'h000400, 8'h40);
        step(3); drv(2, 1, 1, 24'h000301, 8'h31);
        step(3); drv(2, 0, 0, 24'h0, 8'h0);
        step(3); drv(3, 0, 0, 24'h0, 8'h0);
        step(2);
        // reset lands while m1 read sits in LAT; no ack may follow
        t = cyc;
        exp_mem(0, t + 1, 0, 24'h000023, 8'h00);
        drv(1, 1, 0, 24'h000023, 8'h00);
        step(2);
        rst = 1'b0;
        drv(1, 0, 0, 24'h0, 8'h0);
        #1;
        chk("abort_outputs", {cs_a, we_a, addr_a, wd_a, a0.ack, a1.ack, a0.rdata, a1.rdata}, 64'h0);
        step(2);
        rst = 1'b1;
        step(2);
        single(0, 0, 1, 24'h000077, 8'h42, 1, 8'h00, 2);
        // m1 arrives during m0 read ISSUE, gets mem_cs two cycles after m0_ack
        t = cyc;
        exp_mem(0, t + 1, 0, 24'h000040, 8'h00); exp_ack(0, t + 4, 1, 8'h3C);
        exp_mem(0, t + 6, 1, 24'h000050, 8'h66); exp_ack(1, t + 7, 1, 8'h00);
        drv(0, 1, 0, 24'h000040, 8'h00);
        step(1); drv(1, 1, 1, 24'h000050, 8'h66);
        step(4); drv(0, 0, 0, 24'h0, 8'h0);
        step(3); drv(1, 0, 0, 24'h0, 8'h0);
        step(1);
        // request withdrawn and address changed after grant: latched values still complete
        t = cyc;
        exp_mem(0, t + 1, 1, 24'h000060, 8'h61);
        exp_ack(0, t + 2, 1, 8'h3C);
        drv(0, 1, 1, 24'h000060, 8'h61);
        step(1); drv(0, 0, 0, 24'h000FFF, 8'h00);
        step(4);
        chk("ack_expect_left", 64'(qa.size()), 64'h0);
        chk("mem_expect_left", 64'(qm.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
